sara_accuracy_ctrl: RTL and testbench

Closed-loop accuracy controller for the SARA approximate adder: drives the adder's per-group `ApproxRCON` carry-select lines and checks the adder's result against an internally computed exact sum. It accumulates absolute error over a fixed window of accepted samples, then raises or lowers the number of accurate groups with a dual-threshold hysteresis rule. It sits beside a SARA instance, with the adder's operands and result passing through its handshake.

---
 rtl/sara_pkg.sv | 38 +++
 rtl/sara_err_unit.sv | 27 ++
 rtl/sara_accuracy_ctrl.sv | 179 +++++++++++++++++
 tb/tb_sara_accuracy_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sara_pkg.sv
// Shared types and width/encoding helpers for the SARA accuracy controller.
package sara_pkg;

  typedef enum logic [1:0] {
    MEASURE = 2'd0,
    DECIDE  = 2'd1,
    SETTLE  = 2'd2
  } state_e;

  localparam int unsigned MAX_NG = 64;

  function automatic int unsigned f_ng(input int unsigned size, input int unsigned gs);
    return size / gs;
  endfunction

  function automatic int unsigned f_lvl_w(input int unsigned ng);
    return $clog2(ng + 1);
  endfunction

  function automatic int unsigned f_acc_w(input int unsigned size, input int unsigned window);
    return size + 1 + $clog2(window);
  endfunction

  // Bit i (0-based) is set when i < lvl, i.e. the lowest lvl groups run exact.
  function automatic logic [MAX_NG-1:0] f_therm(input int unsigned lvl);
    logic [MAX_NG-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < MAX_NG; i++) begin
      if (i < lvl) begin
        t[i] = 1'b1;
      end else begin
        t[i] = 1'b0;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/sara_err_unit.sv
// Combinational absolute error between the exact sum A+B+CIN and the
// approximate adder result {COUT, SUM}.
module sara_err_unit #(
  parameter int unsigned SIZE = 16
) (
  input  logic [SIZE:1] a_i,
  input  logic [SIZE:1] b_i,
  input  logic          cin_i,
  input  logic [SIZE:1] sum_i,
  input  logic          cout_i,
  output logic [SIZE:0] err_o
);

  logic [SIZE:0] exact_s;
  logic [SIZE:0] approx_s;

  always_comb begin
    exact_s  = {1'b0, a_i} + {1'b0, b_i} + {{SIZE{1'b0}}, cin_i};
    approx_s = {cout_i, sum_i};
    if (exact_s >= approx_s) begin
      err_o = exact_s - approx_s;
    end else begin
      err_o = approx_s - exact_s;
    end
  end

endmodule

// File: rtl/sara_accuracy_ctrl.sv
// Closed-loop accuracy controller for a SARA approximate adder.
// Optional statistics outputs are enabled with `define SARA_CTRL_STATS_EN.
module sara_accuracy_ctrl
  import sara_pkg::*;
#(
  parameter int unsigned SIZE      = 16,
  parameter int unsigned GROUPSIZE = 8,
  parameter int unsigned WINDOW    = 64,
  parameter int unsigned ERR_HI    = 256,
  parameter int unsigned ERR_LO    = 16
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [SIZE:1]                                    A,
  input  logic [SIZE:1]                                    B,
  input  logic                                             CIN,
  input  logic [SIZE:1]                                    APPROX_SUM,
  input  logic                                             APPROX_COUT,
  output logic [SIZE/GROUPSIZE:1]                          ApproxRCON,
  output logic [f_lvl_w(f_ng(SIZE, GROUPSIZE))-1:0]        level,
  output logic                                             window_done
`ifdef SARA_CTRL_STATS_EN
  ,
  output logic [15:0]                                      win_count,
  output logic [SIZE:0]                                    err_peak
`endif
);

  localparam int unsigned NG = f_ng(SIZE, GROUPSIZE);
  localparam int unsigned LW = f_lvl_w(NG);
  localparam int unsigned AW = f_acc_w(SIZE, WINDOW);
  localparam int unsigned CW = $clog2(WINDOW);

  state_e        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [NG:1]   rcon_q, rcon_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;
  logic          done_q, done_d;

  logic [SIZE:0] err_s;
  logic          accept_s;
  logic [AW:0]   acc_sum_s;

  sara_err_unit #(.SIZE(SIZE)) u_err (
    .a_i    (A),
    .b_i    (B),
    .cin_i  (CIN),
    .sum_i  (APPROX_SUM),
    .cout_i (APPROX_COUT),
    .err_o  (err_s)
  );

  // rdy_q is high exactly when the state register holds MEASURE.
  assign accept_s  = in_valid && rdy_q;
  assign acc_sum_s = {1'b0, acc_q} + (AW+1)'(err_s);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      MEASURE: begin
        if (accept_s) begin
          acc_d = acc_sum_s[AW] ? {AW{1'b1}} : acc_sum_s[AW-1:0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WINDOW - 1)) begin
            state_d = DECIDE;
          end else begin
            state_d = MEASURE;
          end
        end else begin
          state_d = MEASURE;
        end
      end
      DECIDE: begin
        acc_d = '0;
        cnt_d = '0;
        // A step that would leave [0, NG] is clamped and treated as no change.
        if (acc_q > AW'(ERR_HI) && level_q != LW'(NG)) begin
          level_d = level_q + LW'(1);
        end else if (acc_q < AW'(ERR_LO) && level_q != LW'(0)) begin
          level_d = level_q - LW'(1);
        end else begin
          level_d = level_q;
        end
        state_d = (level_d != level_q) ? SETTLE : MEASURE;
      end
      SETTLE: begin
        state_d = MEASURE;
      end
      default: begin
        state_d = MEASURE;
      end
    endcase
    rcon_d = NG'(f_therm(32'(level_d)));
    rdy_d  = (state_d == MEASURE);
    done_d = (state_d == DECIDE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEASURE;
      level_q <= LW'(NG);
      rcon_q  <= {NG{1'b1}};
      acc_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      rcon_q  <= rcon_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready    = rdy_q;
  assign window_done = done_q;
  assign level       = level_q;
  assign ApproxRCON  = rcon_q;

`ifdef SARA_CTRL_STATS_EN
  logic [15:0]   win_q, win_d;
  logic [SIZE:0] peak_run_q, peak_run_d;
  logic [SIZE:0] peak_q, peak_d;

  // Running peak is tracked per window and published when the window closes.
  always_comb begin
    win_d      = win_q;
    peak_run_d = peak_run_q;
    peak_d     = peak_q;
    case (state_q)
      MEASURE: begin
        if (accept_s && err_s > peak_run_q) begin
          peak_run_d = err_s;
        end else begin
          peak_run_d = peak_run_q;
        end
      end
      DECIDE: begin
        peak_d     = peak_run_q;
        peak_run_d = '0;
        if (win_q != 16'hFFFF) begin
          win_d = win_q + 16'd1;
        end else begin
          win_d = win_q;
        end
      end
      default: begin
        peak_run_d = peak_run_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q      <= 16'd0;
      peak_run_q <= '0;
      peak_q     <= '0;
    end else begin
      win_q      <= win_d;
      peak_run_q <= peak_run_d;
      peak_q     <= peak_d;
    end
  end

  assign win_count = win_q;
  assign err_peak  = peak_q;
`endif

endmodule

// File: tb/tb_sara_accuracy_ctrl.sv
// Directed self-checking bench for sara_accuracy_ctrl (SIZE=16, GROUPSIZE=8, WINDOW=4).
module tb_sara_accuracy_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:1] A, B, APPROX_SUM;
  logic        CIN, APPROX_COUT;
  logic [2:1]  ApproxRCON;
  logic [1:0]  level;
  logic        window_done;
`ifdef SARA_CTRL_STATS_EN
  logic [15:0] win_count;
  logic [16:0] err_peak;
`endif

  int checks;
  int errors;

  sara_accuracy_ctrl #(
    .SIZE(16), .GROUPSIZE(8), .WINDOW(4), .ERR_HI(256), .ERR_LO(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .CIN         (CIN),
    .APPROX_SUM  (APPROX_SUM),
    .APPROX_COUT (APPROX_COUT),
    .ApproxRCON  (ApproxRCON),
    .level       (level),
    .window_done (window_done)
`ifdef SARA_CTRL_STATS_EN
    ,
    .win_count   (win_count),
    .err_peak    (err_peak)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [16:1] a, input logic [16:1] b, input logic c,
                          input logic [16:1] s, input logic co);
    int w;
    A = a; B = b; CIN = c; APPROX_SUM = s; APPROX_COUT = co;
    in_valid = 1'b1;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    checks++;
    if (w >= 20) begin
      errors++;
      $display("FAIL ready_timeout waited %0d cycles, required in_ready within 20", w);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_window(input logic [16:1] a, input logic [16:1] b, input logic c,
                             input logic [16:1] s, input logic co);
    for (int k = 0; k < 4; k++) send_one(a, b, c, s, co);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0;
    A = '0; B = '0; CIN = 1'b0; APPROX_SUM = '0; APPROX_COUT = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL reset_level got %0d exp 2", level); end
    checks++; if (ApproxRCON !== 2'b11) begin errors++; $display("FAIL reset_rcon got %b exp 11", ApproxRCON); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    checks++; if (window_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", window_done); end
`ifdef SARA_CTRL_STATS_EN
    checks++; if (win_count !== 16'd0) begin errors++; $display("FAIL reset_wincnt got %0d exp 0", win_count); end
`endif
  endtask

  task automatic test_lower();
    send_window(16'd1, 16'd2, 1'b0, 16'd3, 1'b0);
    checks++; if (window_done !== 1'b1) begin errors++; $display("FAIL lower_decide_done got %b exp 1", window_done); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lower_decide_ready got %b exp 0", in_ready); end
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL lower_decide_level got %0d exp 2", level); end
    step();
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL lower_level got %0d exp 1", level); end
    checks++; if (ApproxRCON !== 2'b01) begin errors++; $display("FAIL lower_rcon got %b exp 01", ApproxRCON); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lower_settle_ready got %b exp 0", in_ready); end
    checks++; if (window_done !== 1'b0) begin errors++; $display("FAIL lower_settle_done got %b exp 0", window_done); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lower_measure_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_lower_to_zero();
    // 0xFFFF + 0 + 1 = 0x10000 matches {COUT=1, SUM=0}: zero error.
    send_window(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    step();
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL zero_level got %0d exp 0", level); end
    checks++; if (ApproxRCON !== 2'b00) begin errors++; $display("FAIL zero_rcon got %b exp 00", ApproxRCON); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_settle_ready got %b exp 0", in_ready); end
    step();
  endtask

  task automatic test_clamp_low();
    for (int n = 0; n < 2; n++) begin
      send_window(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
      checks++; if (window_done !== 1'b1) begin errors++; $display("FAIL clamplo_done[%0d] got %b exp 1", n, window_done); end
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clamplo_ready[%0d] got %b exp 1", n, in_ready); end
      checks++; if (level !== 2'd0) begin errors++; $display("FAIL clamplo_level[%0d] got %0d exp 0", n, level); end
    end
  endtask

  task automatic test_raise();
    send_window(16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b0);
    step();
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL raise_level got %0d exp 1", level); end
    checks++; if (ApproxRCON !== 2'b01) begin errors++; $display("FAIL raise_rcon got %b exp 01", ApproxRCON); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raise_settle_ready got %b exp 0", in_ready); end
    step();
  endtask

  task automatic test_between();
    // 100 - 75 = 25 per sample, 100 per window.
    send_window(16'd100, 16'd0, 1'b0, 16'd75, 1'b0);
    checks++; if (window_done !== 1'b1) begin errors++; $display("FAIL between_done got %b exp 1", window_done); end
    step();
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL between_level got %0d exp 1", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL between_ready got %b exp 1", in_ready); end
`ifdef SARA_CTRL_STATS_EN
    checks++; if (err_peak !== 17'd25) begin errors++; $display("FAIL between_peak got %0d exp 25", err_peak); end
    checks++; if (win_count !== 16'd6) begin errors++; $display("FAIL between_wincnt got %0d exp 6", win_count); end
`endif
  endtask

  task automatic test_thresholds();
    send_window(16'd64, 16'd0, 1'b0, 16'd0, 1'b0);
    step();
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL hi_equal_level got %0d exp 1", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hi_equal_ready got %b exp 1", in_ready); end
    send_window(16'd4, 16'd0, 1'b0, 16'd0, 1'b0);
    step();
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL lo_equal_level got %0d exp 1", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lo_equal_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_raise_abs_and_clamp();
    // Approximate result exceeds exact by 0x10000 each sample.
    send_window(16'd0, 16'd0, 1'b0, 16'h0000, 1'b1);
    step();
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL rabs_level got %0d exp 2", level); end
    checks++; if (ApproxRCON !== 2'b11) begin errors++; $display("FAIL rabs_rcon got %b exp 11", ApproxRCON); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rabs_settle_ready got %b exp 0", in_ready); end
    step();
    send_window(16'd0, 16'd0, 1'b0, 16'h0000, 1'b1);
    step();
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL clamphi_level got %0d exp 2", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clamphi_ready got %b exp 1", in_ready); end
`ifdef SARA_CTRL_STATS_EN
    checks++; if (err_peak !== 17'h10000) begin errors++; $display("FAIL clamphi_peak got %0d exp 65536", err_peak); end
`endif
  endtask

  task automatic test_mid_reset();
    A = 16'h00FF; B = 16'h0001; CIN = 1'b0; APPROX_SUM = 16'h0000; APPROX_COUT = 1'b0;
    in_valid = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL mrst_level got %0d exp 2", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready got %b exp 1", in_ready); end
    checks++; if (window_done !== 1'b0) begin errors++; $display("FAIL mrst_done got %b exp 0", window_done); end
`ifdef SARA_CTRL_STATS_EN
    checks++; if (win_count !== 16'd0) begin errors++; $display("FAIL mrst_wincnt got %0d exp 0", win_count); end
    checks++; if (err_peak !== 17'd0) begin errors++; $display("FAIL mrst_peak got %0d exp 0", err_peak); end
`endif
    in_valid = 1'b0;
    send_one(16'd5, 16'd5, 1'b0, 16'd10, 1'b0);
    send_one(16'd5, 16'd5, 1'b0, 16'd10, 1'b0);
    checks++; if (window_done !== 1'b0) begin errors++; $display("FAIL mrst_cnt_clear got done=%b exp 0", window_done); end
    send_one(16'd5, 16'd5, 1'b0, 16'd10, 1'b0);
    send_one(16'd5, 16'd5, 1'b0, 16'd10, 1'b0);
    checks++; if (window_done !== 1'b1) begin errors++; $display("FAIL mrst_decide got %b exp 1", window_done); end
    step();
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL mrst_acc_clear got level %0d exp 1", level); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lower();
    test_lower_to_zero();
    test_clamp_low();
    test_raise();
    test_between();
    test_thresholds();
    test_raise_abs_and_clamp();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
